// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall vectors, FSM states and
// the exception-vector helper.
package pipe_ctrl_pkg;

    localparam int unsigned INST_ADDR_W = 32;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_REDIRECT = 2'd2
    } ctrl_state_e;

    // Handler address wraps modulo 2^32.
    function automatic logic [INST_ADDR_W-1:0] excp_vector(
        input logic [INST_ADDR_W-1:0] base,
        input int unsigned            shift,
        input logic [4:0]             cause
    );
        return base + ({27'b0, cause} << shift);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages (master) and the sequencer (slave).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                   stallreq_if;
    logic                   stallreq_id;
    logic                   stallreq_ex;
    logic                   stallreq_mem;
    logic                   excp_valid;
    logic [4:0]             excp_cause;
    logic [5:0]             stall;
    logic                   flush;
    logic                   pc_load;
    logic [INST_ADDR_W-1:0] new_pc;
    logic                   stall_timeout;
    logic [31:0]            perf_stall_cyc;
    logic [31:0]            perf_flush_cnt;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_cause,
        input  stall, flush, pc_load, new_pc, stall_timeout,
        input  perf_stall_cyc, perf_flush_cnt
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_cause,
        output stall, flush, pc_load, new_pc, stall_timeout,
        output perf_stall_cyc, perf_flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_wdt.sv
// Stall watchdog: counts consecutive PC-stall cycles and raises a sticky flag
// once the pipeline has been held for STALL_TIMEOUT cycles in a row.
module pipe_ctrl_wdt #(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_pc,
    output logic stall_timeout
);

    localparam int unsigned     CNT_W   = $clog2(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Count saturates at CNT_MAX; the flag sets on the edge that would pass it.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (!stall_pc) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall-vector merge, exception flush/redirect FSM and watchdog.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] EXCP_BASE     = 32'h0000_0020,
    parameter int unsigned            VEC_SHIFT     = 3,
    parameter int unsigned            STALL_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    ctrl_state_e            state_q, state_d;
    logic [INST_ADDR_W-1:0] vec_q, vec_d;
    logic [INST_ADDR_W-1:0] new_pc_q, new_pc_d;
    logic                   flush_q, flush_d;
    logic                   pc_load_q, pc_load_d;
    logic [5:0]             stall_vec;

    // Stall is gated by reset so the vector reads zero while rst is held low.
    always_comb begin
        stall_vec = STALL_NONE;
        if (rst && state_q == CTRL_RUN && !bus.excp_valid) begin
            if (bus.stallreq_mem)     stall_vec = STALL_MEM;
            else if (bus.stallreq_ex) stall_vec = STALL_EX;
            else if (bus.stallreq_id) stall_vec = STALL_ID;
            else if (bus.stallreq_if) stall_vec = STALL_IF;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            CTRL_RUN: begin
                if (bus.excp_valid) begin
                    vec_d   = excp_vector(EXCP_BASE, VEC_SHIFT, bus.excp_cause);
                    state_d = CTRL_FLUSH;
                end
            end
            CTRL_FLUSH:    state_d = CTRL_REDIRECT;
            CTRL_REDIRECT: state_d = CTRL_RUN;
            default:       state_d = CTRL_RUN;
        endcase
        // Outputs are registered alongside the state they decode from.
        flush_d   = (state_d == CTRL_FLUSH);
        pc_load_d = (state_d == CTRL_REDIRECT);
        new_pc_d  = (state_d == CTRL_REDIRECT) ? vec_q : new_pc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CTRL_RUN;
            vec_q     <= '0;
            new_pc_q  <= '0;
            flush_q   <= 1'b0;
            pc_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            new_pc_q  <= new_pc_d;
            flush_q   <= flush_d;
            pc_load_q <= pc_load_d;
        end
    end

    pipe_ctrl_wdt #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_wdt (
        .clk          (clk),
        .rst          (rst),
        .stall_pc     (stall_vec[0]),
        .stall_timeout(bus.stall_timeout)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'b0, stall_vec[0]};
        perf_flush_d = perf_flush_q + {31'b0, (state_q == CTRL_FLUSH)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign bus.perf_stall_cyc = perf_stall_q;
    assign bus.perf_flush_cnt = perf_flush_q;
`else
    assign bus.perf_stall_cyc = '0;
    assign bus.perf_flush_cnt = '0;
`endif

    assign bus.stall   = stall_vec;
    assign bus.flush   = flush_q;
    assign bus.pc_load = pc_load_q;
    assign bus.new_pc  = new_pc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam logic [31:0] EXCP_BASE = 32'h0000_0020;
    localparam int unsigned VEC_SHIFT = 3;
    localparam int unsigned TIMEOUT   = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .EXCP_BASE    (EXCP_BASE),
        .VEC_SHIFT    (VEC_SHIFT),
        .STALL_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 = running, 1 = flushing, 2 = redirecting.
    int          m_phase;
    logic [31:0] m_vec;
    logic [31:0] m_newpc;
    int          m_run;
    logic        m_timeout;
    logic [31:0] m_perf_s;
    logic [31:0] m_perf_f;

    function automatic void model_reset();
        m_phase   = 0;
        m_vec     = '0;
        m_newpc   = '0;
        m_run     = 0;
        m_timeout = 1'b0;
        m_perf_s  = '0;
        m_perf_f  = '0;
    endfunction

    // req bit0..3 = if, id, ex, mem; the highest asserted stage freezes itself and all earlier ones.
    function automatic logic [5:0] model_stall(input logic [3:0] req, input logic ev);
        logic [5:0] s;
        s = 6'b0;
        if (m_phase == 0 && !ev) begin
            for (int i = 3; i >= 0; i--) begin
                if (req[i] && s == 6'b0) s = 6'((1 << (i + 2)) - 1);
            end
        end
        return s;
    endfunction

    task automatic set_inputs(input logic [3:0] req, input logic ev, input logic [4:0] cause);
        bus.stallreq_if  = req[0];
        bus.stallreq_id  = req[1];
        bus.stallreq_ex  = req[2];
        bus.stallreq_mem = req[3];
        bus.excp_valid   = ev;
        bus.excp_cause   = cause;
    endtask

    // One clock: drive at negedge, compare combinational stall, then registered outputs after the edge.
    task automatic step(input logic [3:0] req, input logic ev, input logic [4:0] cause);
        logic [5:0]  exp_s;
        logic [31:0] exp_ps, exp_pf;
        @(negedge clk);
        set_inputs(req, ev, cause);
        #1;
        exp_s = model_stall(req, ev);
        checks++;
        if (bus.stall !== exp_s) begin
            errors++;
            $display("FAIL stall t=%0t got=%b exp=%b", $time, bus.stall, exp_s);
        end
        @(posedge clk);
        if (exp_s[0]) m_run++; else m_run = 0;
        if (m_run >= int'(TIMEOUT)) m_timeout = 1'b1;
        m_perf_s = m_perf_s + {31'b0, exp_s[0]};
        if (m_phase == 1) m_perf_f = m_perf_f + 32'd1;
        if (m_phase == 0 && ev) begin
            m_vec   = EXCP_BASE + (32'(cause) << VEC_SHIFT);
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_newpc = m_vec;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
        #1;
`ifdef PIPE_PERF_CNT_EN
        exp_ps = m_perf_s;
        exp_pf = m_perf_f;
`else
        exp_ps = '0;
        exp_pf = '0;
`endif
        checks += 6;
        if (bus.flush !== (m_phase == 1)) begin
            errors++;
            $display("FAIL flush t=%0t got=%b exp=%b", $time, bus.flush, (m_phase == 1));
        end
        if (bus.pc_load !== (m_phase == 2)) begin
            errors++;
            $display("FAIL pc_load t=%0t got=%b exp=%b", $time, bus.pc_load, (m_phase == 2));
        end
        if (bus.new_pc !== m_newpc) begin
            errors++;
            $display("FAIL new_pc t=%0t got=%h exp=%h", $time, bus.new_pc, m_newpc);
        end
        if (bus.stall_timeout !== m_timeout) begin
            errors++;
            $display("FAIL stall_timeout t=%0t got=%b exp=%b", $time, bus.stall_timeout, m_timeout);
        end
        if (bus.perf_stall_cyc !== exp_ps) begin
            errors++;
            $display("FAIL perf_stall_cyc t=%0t got=%0d exp=%0d", $time, bus.perf_stall_cyc, exp_ps);
        end
        if (bus.perf_flush_cnt !== exp_pf) begin
            errors++;
            $display("FAIL perf_flush_cnt t=%0t got=%0d exp=%0d", $time, bus.perf_flush_cnt, exp_pf);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_inputs(4'b0, 1'b0, 5'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        set_inputs(4'b1111, 1'b1, 5'd7);
        repeat (2) begin
            @(posedge clk);
            #2;
            checks += 4;
            if (bus.stall !== 6'b0) begin
                errors++;
                $display("FAIL reset_stall got=%b exp=000000", bus.stall);
            end
            if (bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush got=%b exp=0", bus.flush);
            end
            if (bus.pc_load !== 1'b0) begin
                errors++;
                $display("FAIL reset_pc_load got=%b exp=0", bus.pc_load);
            end
            if (bus.stall_timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_timeout got=%b exp=0", bus.stall_timeout);
            end
        end
        @(negedge clk);
        set_inputs(4'b0, 1'b0, 5'd0);
        rst = 1'b1;
        model_reset();
        step(4'b0000, 1'b0, 5'd0);
    endtask

    task automatic test_priority();
        do_reset();
        step(4'b1010, 1'b0, 5'd0);
        checks++;
        if (bus.stall !== 6'b011111) begin
            errors++;
            $display("FAIL prio_id_mem got=%b exp=011111", bus.stall);
        end
        step(4'b0010, 1'b0, 5'd0);
        checks++;
        if (bus.stall !== 6'b000111) begin
            errors++;
            $display("FAIL prio_id got=%b exp=000111", bus.stall);
        end
        step(4'b0001, 1'b0, 5'd0);
        checks++;
        if (bus.stall !== 6'b000011) begin
            errors++;
            $display("FAIL prio_if got=%b exp=000011", bus.stall);
        end
        step(4'b0100, 1'b0, 5'd0);
        step(4'b0000, 1'b0, 5'd0);
    endtask

    task automatic test_exception();
        do_reset();
        step(4'b0100, 1'b1, 5'd4);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL excp_flush got=%b exp=1", bus.flush);
        end
        step(4'b0100, 1'b1, 5'd9);
        checks += 2;
        if (bus.pc_load !== 1'b1) begin
            errors++;
            $display("FAIL excp_pc_load got=%b exp=1", bus.pc_load);
        end
        if (bus.new_pc !== 32'h40) begin
            errors++;
            $display("FAIL excp_new_pc got=%h exp=00000040", bus.new_pc);
        end
        step(4'b0000, 1'b0, 5'd0);
        step(4'b0000, 1'b0, 5'd0);
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL excp_dropped got=%b exp=0", bus.flush);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(4'b0000, 1'b1, 5'd3);
        #2;
        rst = 1'b0;
        #1;
        checks += 2;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL async_flush got=%b exp=0", bus.flush);
        end
        if (bus.pc_load !== 1'b0) begin
            errors++;
            $display("FAIL async_pc_load got=%b exp=0", bus.pc_load);
        end
        set_inputs(4'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) step(4'b0000, 1'b0, 5'd0);
    endtask

    task automatic test_watchdog();
        do_reset();
        repeat (7) step(4'b0001, 1'b0, 5'd0);
        checks++;
        if (bus.stall_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdt_7 got=%b exp=0", bus.stall_timeout);
        end
        step(4'b0000, 1'b0, 5'd0);
        repeat (8) step(4'b0001, 1'b0, 5'd0);
        checks++;
        if (bus.stall_timeout !== 1'b1) begin
            errors++;
            $display("FAIL wdt_8 got=%b exp=1", bus.stall_timeout);
        end
        repeat (2) step(4'b0000, 1'b0, 5'd0);
        checks++;
        if (bus.stall_timeout !== 1'b1) begin
            errors++;
            $display("FAIL wdt_sticky got=%b exp=1", bus.stall_timeout);
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_s, exp_f;
        do_reset();
        repeat (5) step(4'b0100, 1'b0, 5'd0);
        step(4'b0000, 1'b1, 5'($urandom_range(31)));
        repeat (3) step(4'b0000, 1'b0, 5'd0);
        step(4'b0000, 1'b1, 5'($urandom_range(31)));
        repeat (3) step(4'b0000, 1'b0, 5'd0);
`ifdef PIPE_PERF_CNT_EN
        exp_s = 32'd5;
        exp_f = 32'd2;
`else
        exp_s = 32'd0;
        exp_f = 32'd0;
`endif
        checks += 2;
        if (bus.perf_stall_cyc !== exp_s) begin
            errors++;
            $display("FAIL perf_stall got=%0d exp=%0d", bus.perf_stall_cyc, exp_s);
        end
        if (bus.perf_flush_cnt !== exp_f) begin
            errors++;
            $display("FAIL perf_flush got=%0d exp=%0d", bus.perf_flush_cnt, exp_f);
        end
    endtask

    task automatic test_random();
        logic [3:0] req;
        logic       ev;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req = 4'($urandom_range(15));
            if ($urandom_range(3) == 0) req = 4'b0;
            ev  = ($urandom_range(9) == 0);
            step(req, ev, 5'($urandom_range(31)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        set_inputs(4'b0, 1'b0, 5'd0);
        model_reset();
        test_reset();
        test_priority();
        test_exception();
        test_async_reset();
        test_watchdog();
        test_perf();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout time limit expired");
        $fatal(1, "time limit expired");
    end

endmodule
